serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, multi-cycle, bit-serial successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands one bit per clock through one full-adder cell and a registered carry.
- Uses a start/busy/done handshake.
- Serves as the datapath adder for the multi-cycle ALU lab, where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  mode, sampled with start: 0 = a+b+cin, 1 = a-b (cin ignored)
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- cin  input  1  carry-in, sampled with start (add mode only)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result valid
- s  output  WIDTH  sum/difference, held until the next accepted start
- cout  output  1  carry out of the MSB; in sub mode 1 = no borrow
- ovf  output  1  signed overflow of the MSB stage

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, s, cout, ovf all 0; internal shift registers, bit counter and carry cleared. Reset mid-operation aborts it, and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - latch opA=a and opB=(sub ? ~b : b);
  - carry = (sub ? 1 : cin);
  - count=0; go to RUN.
  - busy=1 from edge k; s/cout/ovf keep their previous values until completion.
- RUN, each edge:
  - bit = opA[0]^opB[0]^carry;
  - carry = maj(opA[0],opB[0],carry);
  - shift opA and opB right by 1;
  - shift bit into the result register from the MSB side;
  - count++.
- On the WIDTH-th RUN edge (edge k+WIDTH):
  - s = the completed result register;
  - cout = final carry;
  - ovf = carry into MSB XOR carry out of MSB;
  - go to DONE, with done=1 and busy=0 after edge k+WIDTH.
- Latency: exactly WIDTH cycles from the accepting edge to done.
- DONE lasts one cycle; done returns to 0 on the next edge.
  - start=1 in DONE is accepted exactly as in IDLE: next state RUN, done drops, busy rises.
  - Otherwise the next state is IDLE.
- start while busy=1 is ignored, and operand/mode changes during RUN have no effect.
- WIDTH=1: RUN lasts one cycle. The result must match the full-adder truth table, with ovf = cin XOR cout.
- Wrap-around: s is modulo 2^WIDTH, and overflow is reported only via cout/ovf.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. WIDTH=8, start with a=0x0F, b=0x01, cin=0, sub=0 -> exactly 8 cycles later done=1 for one cycle; s=0x10, cout=0, ovf=0; busy high for the 8 cycles in between.
2. WIDTH=8, add 0xFF+0x01 cin=0 -> s=0x00, cout=1, ovf=0. Add 0x7F+0x01 -> s=0x80, cout=0, ovf=1. Add 0x80+0x80 -> s=0x00, cout=1, ovf=1.
3. WIDTH=8, sub=1, a=0x05, b=0x07, cin=1 -> s=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01 -> s=0x7F, cout=1, ovf=1.
4. WIDTH=8, pulse start again at cycle 3 of a run with different operands -> the first result is unaffected, no extra done, and busy stays high. Assert start during the done cycle -> the new operation is accepted back-to-back and its done arrives 8 cycles later.
5. WIDTH=8, drop rst_n asynchronously mid-RUN (between clock edges) -> busy, done, s, cout and ovf all go to 0 immediately. No done follows, and the next start completes correctly.
6. WIDTH=1, all 8 combinations of a/b/cin in add mode -> done after 1 cycle; s/cout equal the full-adder truth table, and ovf=cin^cout.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract unit. One full-adder cell and a
// registered carry process one bit per clock, LSB first, with a
// start/busy/done handshake. Results are reported through registered outputs.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Majority of three inputs: the carry out of one full-adder cell.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic             sum_bit_s;
  logic             carry_next_s;
  logic [WIDTH:0]   res_ext_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;
  logic             accept_s;

  // Full-adder cell on the current LSBs plus the next result image.
  always_comb begin
    sum_bit_s    = op_a_r[0] ^ op_b_r[0] ^ carry_r;
    carry_next_s = maj3(op_a_r[0], op_b_r[0], carry_r);
    res_ext_s    = {sum_bit_s, res_r};
    res_next_s   = res_ext_s[WIDTH:1];
    last_s       = (state_r == RUN) && (count_r == LAST_BIT);
    accept_s     = start && (state_r != RUN);
  end

  // Next-state logic: a start is honoured in IDLE and in the DONE cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (count_r == LAST_BIT) state_s = DONE;
        else                     state_s = RUN;
      end
      DONE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Operand shift registers, carry, bit counter and partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r  <= {WIDTH{1'b0}};
      op_b_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      count_r <= {CW{1'b0}};
    end else if (accept_s) begin
      // Subtraction is a + ~b + 1, so the inverted operand and a forced
      // carry-in are loaded up front.
      op_a_r  <= a;
      op_b_r  <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : cin;
      count_r <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      op_a_r  <= op_a_r >> 1;
      op_b_r  <= op_b_r >> 1;
      res_r   <= res_next_s;
      carry_r <= carry_next_s;
      count_r <= count_r + CW'(1'b1);
    end
  end

  // Registered handshake flags and result capture on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      s_r    <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
      if (last_s) begin
        s_r    <= res_next_s;
        cout_r <= carry_next_s;
        // carry_r is the carry into the MSB during the last step.
        ovf_r  <= carry_r ^ carry_next_s;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: one WIDTH=8 and one WIDTH=1 instance,
// directed cases plus random operations checked against an arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel, start, sub, cin;
  logic [7:0] a, b;
  logic       start8, start1;

  logic       busy8, done8, cout8, ovf8;
  logic [7:0] s8;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] s1;

  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;
  logic [7:0] prev_s8 = 8'h00;
  logic [7:0] prev_s1 = 8'h00;

  always #5 clk = ~clk;

  assign start8 = start & ~sel;
  assign start1 = start & sel;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a[0:0]), .b(b[0:0]),
    .cin(cin), .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
  );

  function automatic logic o_busy(); return sel ? busy1 : busy8; endfunction
  function automatic logic o_done(); return sel ? done1 : done8; endfunction
  function automatic logic o_cout(); return sel ? cout1 : cout8; endfunction
  function automatic logic o_ovf();  return sel ? ovf1  : ovf8;  endfunction
  function automatic logic [7:0] o_s(); return sel ? {7'b0, s1} : s8; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  task automatic model(input int w, input bit sb, input logic [7:0] aa, input logic [7:0] bb,
                       input bit ci, output logic [7:0] es, output bit ec, output bit eo);
    int mask, x, y, full, am, bm, sm;
    mask = (1 << w) - 1;
    x = int'(aa) & mask;
    y = int'(bb) & mask;
    if (sb) full = x + ((~y) & mask) + 1;
    else    full = x + y + int'(ci);
    es = 8'(full & mask);
    ec = ((full >> w) & 1) != 0;
    am = (x >> (w - 1)) & 1;
    bm = (y >> (w - 1)) & 1;
    sm = (full >> (w - 1)) & 1;
    if (sb) eo = (am != bm) && (sm != am);
    else    eo = (am == bm) && (sm != am);
  endtask

  // Caller is at a negedge. Issues one operation and checks it through done.
  task automatic run_op(input bit w1, input bit sb, input logic [7:0] aa, input logic [7:0] bb,
                        input bit ci, input bit intrude, input string tag);
    logic [7:0] es, held;
    bit ec, eo;
    int w, cyc, bcnt;
    w = w1 ? 1 : 8;
    model(w, sb, aa, bb, ci, es, ec, eo);
    held = w1 ? prev_s1 : prev_s8;
    sel = w1; sub = sb; a = aa; b = bb; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s/busy_accept", tag), 32'(o_busy()), 32'd1);
    chk($sformatf("%s/done_accept", tag), 32'(o_done()), 32'd0);
    chk($sformatf("%s/s_held", tag), 32'(o_s()), 32'(held));
    // Operand/mode changes during the run must not matter.
    a = 8'($urandom); b = 8'($urandom); sub = ~sb; cin = ~ci;
    cyc = 0; bcnt = 0;
    while (!o_done() && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (intrude && cyc == 3) start = 1'b1;
      else                     start = 1'b0;
      if (!o_done() && o_busy()) bcnt++;
    end
    start = 1'b0;
    chk($sformatf("%s/latency", tag), 32'(cyc), 32'(w));
    chk($sformatf("%s/busy_cycles", tag), 32'(bcnt), 32'(w - 1));
    chk($sformatf("%s/done", tag), 32'(o_done()), 32'd1);
    chk($sformatf("%s/busy_at_done", tag), 32'(o_busy()), 32'd0);
    chk($sformatf("%s/s", tag), 32'(o_s()), 32'(es));
    chk($sformatf("%s/cout", tag), 32'(o_cout()), 32'(ec));
    chk($sformatf("%s/ovf", tag), 32'(o_ovf()), 32'(eo));
    if (w1) prev_s1 = es;
    else    prev_s8 = es;
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    chk($sformatf("%s/done_drop", tag), 32'(o_done()), 32'd0);
    chk($sformatf("%s/idle_busy", tag), 32'(o_busy()), 32'd0);
    chk($sformatf("%s/s_hold", tag), 32'(o_s()), 32'(sel ? prev_s1 : prev_s8));
  endtask

  initial begin
    int dcnt;
    sel = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst/busy8", 32'(busy8), 32'd0);
    chk("rst/done8", 32'(done8), 32'd0);
    chk("rst/s8", 32'(s8), 32'd0);
    chk("rst/cout8", 32'(cout8), 32'd0);
    chk("rst/ovf8", 32'(ovf8), 32'd0);
    chk("rst/busy1", 32'(busy1), 32'd0);
    chk("rst/s1", 32'(s1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 1'b0, 8'h0F, 8'h01, 1'b0, 1'b0, "t1");
    check_quiet("t1");
    run_op(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "t2a");
    run_op(1'b0, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, "t2b");
    run_op(1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0, "t2c");
    check_quiet("t2");
    run_op(1'b0, 1'b1, 8'h05, 8'h07, 1'b1, 1'b0, "t3a");
    run_op(1'b0, 1'b1, 8'h80, 8'h01, 1'b0, 1'b0, "t3b");
    check_quiet("t3");

    // Ignored start mid-run, then back-to-back start in the done cycle.
    run_op(1'b0, 1'b0, 8'h3C, 8'h5A, 1'b1, 1'b1, "t4a");
    run_op(1'b0, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, "t4b");
    check_quiet("t4");

    // Asynchronous reset in the middle of a run.
    sel = 1'b0; sub = 1'b0; a = 8'hAA; b = 8'h11; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5/busy", 32'(busy8), 32'd0);
    chk("t5/done", 32'(done8), 32'd0);
    chk("t5/s", 32'(s8), 32'd0);
    chk("t5/cout", 32'(cout8), 32'd0);
    chk("t5/ovf", 32'(ovf8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_s8 = 8'h00;
    prev_s1 = 8'h00;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) dcnt++;
    end
    chk("t5/no_done_after_reset", 32'(dcnt), 32'd0);
    run_op(1'b0, 1'b0, 8'h21, 8'h43, 1'b1, 1'b0, "t5r");
    check_quiet("t5r");

    // WIDTH=1 full-adder truth table, then subtract mode.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op(1'b1, 1'b0, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1'b0, $sformatf("t6_%0d", i));
    end
    check_quiet("t6");
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      run_op(1'b1, 1'b1, {7'b0, v[1]}, {7'b0, v[0]}, 1'b0, 1'b0, $sformatf("t6s_%0d", i));
    end

    // Random operations on both widths, occasionally back-to-back.
    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
             8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $sformatf("rnd_%0d", i));
      if ($urandom_range(0, 1) == 1) check_quiet($sformatf("rnd_%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

endmodule
